program_loader: RTL and testbench

- Writer-side counterpart to the 14-bit instruction program memory that the CPU fetches from.
- Receives a framed byte stream, for example from a UART receiver, and assembles 14-bit instruction words.
- Writes those words to sequential 11-bit program-RAM addresses.
- Holds the CPU in reset while loading, verifies an 8-bit checksum, then releases the CPU.

---
 rtl/loader_pkg.sv | 28 ++
 rtl/program_loader.sv | 154 +++++++++++++++
 tb/tb_program_loader.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the program-memory loader.
package loader_pkg;

    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned DATA_W    = 14;
    localparam int unsigned CNT_W     = 12;
    localparam int unsigned MAX_WORDS = 2048;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CNT_H,
        ST_CNT_L,
        ST_DAT_H,
        ST_DAT_L,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    // True while the loader is consuming frame bytes.
    function automatic logic is_receiving(input state_e s);
        return (s == ST_SYNC) || (s == ST_CNT_H) || (s == ST_CNT_L) ||
               (s == ST_DAT_H) || (s == ST_DAT_L) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/program_loader.sv
// Framed byte stream -> 14-bit program-RAM writes, with checksum and CPU hold.
module program_loader
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              pram_we,
    output logic [ADDR_W-1:0] pram_addr,
    output logic [DATA_W-1:0] pram_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  word_cnt
);

    state_e             state_q;
    state_e             state_d;
    logic [7:0]         cnt_h_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [5:0]         wh_q;
    logic [7:0]         sum_q;
    logic [ADDR_W-1:0]  ptr_q;

    logic               hs;
    logic               load_start;
    logic [CNT_W-1:0]   cnt_full;
    logic [7:0]         sum_next;
    logic               last_word;
    logic               cnt_bad;

    // Handshake and frame-field decode shared by the FSM and datapath.
    always_comb begin
        hs         = rx_valid && rx_ready;
        load_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                               (state_q == ST_ERR));
        cnt_full   = {cnt_h_q[3:0], rx_data};
        sum_next   = sum_q + rx_data;
        last_word  = (word_cnt + CNT_W'(1)) == cnt_q;
        cnt_bad    = (cnt_h_q[7:4] != 4'd0) || (cnt_full == CNT_W'(0)) ||
                     (cnt_full > CNT_W'(MAX_WORDS));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every receiving state advances only on a handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (hs && (rx_data == SYNC_BYTE)) state_d = ST_CNT_H;
            end
            ST_CNT_H: begin
                if (hs) state_d = ST_CNT_L;
            end
            ST_CNT_L: begin
                if (hs) state_d = cnt_bad ? ST_ERR : ST_DAT_H;
            end
            ST_DAT_H: begin
                if (hs) state_d = (rx_data[7:6] != 2'b00) ? ST_ERR : ST_DAT_L;
            end
            ST_DAT_L: begin
                if (hs) state_d = last_word ? ST_CSUM : ST_DAT_H;
            end
            ST_CSUM: begin
                if (hs) state_d = (sum_next == 8'h00) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state register; ERR keeps the CPU held.
    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        if (is_receiving(state_q)) begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            cpu_hold = 1'b1;
        end
        if (state_q == ST_DONE) begin
            done = 1'b1;
        end
        if (state_q == ST_ERR) begin
            err      = 1'b1;
            cpu_hold = 1'b1;
        end
    end

    // Count capture, checksum accumulation, word assembly and the RAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_h_q   <= 8'h00;
            cnt_q     <= '0;
            wh_q      <= 6'd0;
            sum_q     <= 8'h00;
            ptr_q     <= '0;
            word_cnt  <= '0;
            pram_we   <= 1'b0;
            pram_addr <= '0;
            pram_data <= '0;
        end else begin
            pram_we <= 1'b0;
            if (load_start) begin
                sum_q    <= 8'h00;
                ptr_q    <= '0;
                word_cnt <= '0;
            end
            if (hs) begin
                case (state_q)
                    ST_CNT_H: begin
                        cnt_h_q <= rx_data;
                        sum_q   <= sum_next;
                    end
                    ST_CNT_L: begin
                        cnt_q <= cnt_full;
                        sum_q <= sum_next;
                    end
                    ST_DAT_H: begin
                        wh_q  <= rx_data[5:0];
                        sum_q <= sum_next;
                    end
                    ST_DAT_L: begin
                        pram_we   <= 1'b1;
                        pram_addr <= ptr_q;
                        pram_data <= {wh_q, rx_data};
                        ptr_q     <= ptr_q + ADDR_W'(1);
                        word_cnt  <= word_cnt + CNT_W'(1);
                        sum_q     <= sum_next;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomised self-checking bench for program_loader with a frame-parsing reference model.
module tb_program_loader;
    import loader_pkg::*;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              pram_we;
    logic [ADDR_W-1:0] pram_addr;
    logic [DATA_W-1:0] pram_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  word_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Expected results from the model.
    logic [ADDR_W-1:0] exp_addr[$];
    logic [DATA_W-1:0] exp_data[$];
    int                exp_wl_idx[$];
    logic              exp_done, exp_err, exp_busy, exp_hold;
    logic [CNT_W-1:0]  exp_wc;
    int                exp_used;

    // Observed writes and handshake times.
    logic [ADDR_W-1:0] obs_addr[$];
    logic [DATA_W-1:0] obs_data[$];
    int                obs_cyc[$];
    int                hs_cyc[$];

    program_loader dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .pram_we(pram_we), .pram_addr(pram_addr), .pram_data(pram_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pram_we) begin
            obs_addr.push_back(pram_addr);
            obs_data.push_back(pram_data);
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Parse a byte stream the way the frame format defines it.
    task automatic model(input bq_t s);
        int i;
        int cnt;
        logic [7:0] sum, h, l;
        exp_addr.delete(); exp_data.delete(); exp_wl_idx.delete();
        exp_done = 0; exp_err = 0; exp_busy = 1; exp_wc = '0;
        i = 0;
        while (i < s.size() && s[i] != 8'hA5) i++;
        i++;
        exp_used = s.size();
        if (i + 2 > s.size()) begin exp_hold = 1; return; end
        h = s[i]; l = s[i+1]; i += 2;
        sum = h + l;
        cnt = int'(h[3:0]) * 256 + int'(l);
        if (h[7:4] != 4'd0 || cnt == 0 || cnt > 2048) begin
            exp_err = 1; exp_busy = 0; exp_hold = 1; exp_used = i; return;
        end
        for (int w = 0; w < cnt; w++) begin
            if (i + 2 > s.size()) begin exp_hold = 1; return; end
            h = s[i]; i++; sum += h;
            if (h[7:6] != 2'b00) begin
                exp_err = 1; exp_busy = 0; exp_hold = 1; exp_used = i; return;
            end
            l = s[i]; exp_wl_idx.push_back(i); i++; sum += l;
            exp_addr.push_back(ADDR_W'(w));
            exp_data.push_back({h[5:0], l});
            exp_wc = CNT_W'(w + 1);
        end
        if (i >= s.size()) begin exp_hold = 1; return; end
        sum += s[i]; i++;
        exp_used = i;
        exp_busy = 0;
        if (sum == 8'h00) begin exp_done = 1; exp_hold = 0; end
        else begin exp_err = 1; exp_hold = 1; end
    endtask

    function automatic bq_t bytes_of(input logic [63:0] v, input int n);
        bq_t s;
        for (int i = 0; i < n; i++) s.push_back(v[63-8*i -: 8]);
        return s;
    endfunction

    function automatic bq_t directed_frame(input int t);
        bq_t s, tmp;
        case (t)
            0: s = bytes_of(64'hA500_0230_0000_8D41, 8);
            1: begin
                s = bytes_of(64'h00FF_0000_0000_0000, 2);
                tmp = bytes_of(64'hA500_0230_0000_8D41, 8);
                foreach (tmp[i]) s.push_back(tmp[i]);
            end
            2: s = bytes_of(64'hA500_0230_0000_8D40, 8);
            3: s = bytes_of(64'hA510_0002_0000_0000, 4);
            4: s = bytes_of(64'hA500_0000_0000_0000, 3);
            5: s = bytes_of(64'hA500_0240_0000_8D41, 8);
            default: s = bytes_of(64'hA508_0100_0000_0000, 3);
        endcase
        return s;
    endfunction

    function automatic bq_t random_frame(input int n, input bit allow_faults);
        bq_t s;
        logic [7:0] sum, b;
        logic [13:0] w;
        if (allow_faults) begin
            repeat ($urandom_range(2, 0)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                s.push_back(b);
            end
        end
        s.push_back(8'hA5);
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        sum = 8'(n >> 8) + 8'(n);
        for (int i = 0; i < n; i++) begin
            w = 14'($urandom);
            b = {2'b00, w[13:8]};
            if (allow_faults && $urandom_range(40, 0) == 0) b[7] = 1'b1;
            s.push_back(b); sum += b;
            s.push_back(w[7:0]); sum += w[7:0];
        end
        b = 8'h00 - sum;
        if (allow_faults && $urandom_range(3, 0) == 0) b = b ^ 8'(32'd1 << $urandom_range(7, 0));
        s.push_back(b);
        return s;
    endfunction

    // Pulse start, then present n bytes with random idle gaps, recording handshake cycles.
    task automatic drive_frame(input bq_t s, input int n, input int max_gap);
        int waited;
        hs_cyc.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < n; k++) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = s[k];
            waited = 0;
            while (!rx_ready && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (!rx_ready) begin
                vectors++; miscompares++;
                $display("FAIL handshake_timeout byte %0d: rx_ready=%b required 1", k, rx_ready);
                rx_valid = 1'b0;
                return;
            end
            hs_cyc.push_back(cyc);
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_ready, pram_we, pram_addr, pram_data, cpu_hold, busy, done, err, word_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b wc=%0d required all 0",
                     rx_ready, pram_we, pram_addr, pram_data, cpu_hold, busy, done, err, word_cnt);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL start_during_reset: busy=%b rx_ready=%b required 0 0", busy, rx_ready);
        end
    endtask

    task automatic test_frames();
        bq_t s;
        for (int t = 0; t < 15; t++) begin
            if (t < 7) s = directed_frame(t);
            else s = random_frame($urandom_range(24, 1), 1'b1);
            model(s);
            clear_obs();
            drive_frame(s, exp_used, (t < 7) ? 0 : 3);
            repeat (2) @(negedge clk);
            vectors++;
            if (obs_addr.size() != exp_addr.size()) begin
                miscompares++;
                $display("FAIL frame%0d_nwrites: got %0d required %0d", t, obs_addr.size(), exp_addr.size());
            end
            for (int j = 0; j < exp_addr.size() && j < obs_addr.size(); j++) begin
                vectors++;
                if (obs_addr[j] !== exp_addr[j] || obs_data[j] !== exp_data[j]) begin
                    miscompares++;
                    $display("FAIL frame%0d_write%0d: got %h/%h required %h/%h", t, j,
                             obs_addr[j], obs_data[j], exp_addr[j], exp_data[j]);
                end
                vectors++;
                if (exp_wl_idx[j] >= hs_cyc.size() || obs_cyc[j] != hs_cyc[exp_wl_idx[j]] + 1) begin
                    miscompares++;
                    $display("FAIL frame%0d_latency%0d: write at cycle %0d, required one cycle after WL", t, j, obs_cyc[j]);
                end
            end
            vectors++;
            if ({done, err, busy, cpu_hold} !== {exp_done, exp_err, exp_busy, exp_hold}) begin
                miscompares++;
                $display("FAIL frame%0d_status: done/err/busy/hold=%b%b%b%b required %b%b%b%b", t,
                         done, err, busy, cpu_hold, exp_done, exp_err, exp_busy, exp_hold);
            end
            vectors++;
            if (word_cnt !== exp_wc) begin
                miscompares++;
                $display("FAIL frame%0d_word_cnt: got %0d required %0d", t, word_cnt, exp_wc);
            end
        end
    endtask

    task automatic test_mid_reset();
        bq_t s;
        s = directed_frame(0);
        clear_obs();
        drive_frame(s, 5, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({rx_ready, pram_we, pram_addr, pram_data, cpu_hold, busy, done, err, word_cnt} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: rdy=%b we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b wc=%0d required all 0",
                     rx_ready, pram_we, pram_addr, pram_data, cpu_hold, busy, done, err, word_cnt);
        end
        vectors++;
        if (obs_addr.size() != 1 || obs_data[0] !== 14'h3000) begin
            miscompares++;
            $display("FAIL midreset_first_write: writes=%0d required 1 of 3000", obs_addr.size());
        end
        model(s);
        clear_obs();
        drive_frame(s, exp_used, 1);
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 11'h000 || obs_data[0] !== 14'h3000 ||
            obs_addr[1] !== 11'h001 || obs_data[1] !== 14'h008D) begin
            miscompares++;
            $display("FAIL reload_writes: count=%0d required 2 writes 000:3000 001:008D", obs_addr.size());
        end
        vectors++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || word_cnt !== 12'd2) begin
            miscompares++;
            $display("FAIL reload_status: done=%b hold=%b wc=%0d required 1 0 2", done, cpu_hold, word_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bq_t s;
        s = random_frame(2048, 1'b0);
        model(s);
        clear_obs();
        fork
            drive_frame(s, exp_used, 0);
            begin
                repeat (1000) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_addr.size() != 2048) begin
            miscompares++;
            $display("FAIL b2b_nwrites: got %0d required 2048", obs_addr.size());
        end
        for (int j = 0; j < 2048 && j < obs_addr.size(); j++) begin
            vectors++;
            if (obs_addr[j] !== exp_addr[j] || obs_data[j] !== exp_data[j] ||
                obs_cyc[j] != hs_cyc[exp_wl_idx[j]] + 1) begin
                miscompares++;
                $display("FAIL b2b_write%0d: got %h/%h required %h/%h", j,
                         obs_addr[j], obs_data[j], exp_addr[j], exp_data[j]);
            end
        end
        vectors++;
        if (obs_addr.size() == 0 || obs_addr[obs_addr.size()-1] !== 11'h7FF) begin
            miscompares++;
            $display("FAIL b2b_last_addr: required 7ff");
        end
        vectors++;
        if (hs_cyc.size() != exp_used || hs_cyc[hs_cyc.size()-1] - hs_cyc[0] != exp_used - 1) begin
            miscompares++;
            $display("FAIL b2b_throughput: %0d handshakes, required %0d on consecutive cycles", hs_cyc.size(), exp_used);
        end
        vectors++;
        if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0 || word_cnt !== 12'd2048) begin
            miscompares++;
            $display("FAIL b2b_status: done=%b err=%b hold=%b busy=%b wc=%0d required 1 0 0 0 2048",
                     done, err, cpu_hold, busy, word_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
